tdoa_lag_producer: RTL and testbench
====================================

# tdoa_lag_producer

Producer side of the 36-bit lag bus (`lagsin` / `lagsinvalid`) consumed by the SOPC lag peripheral. It accepts streamed cross-correlation values for three microphone pairs and tracks the arg-max lag of each pair. When a frame completes, it emits the three signed lags packed into one 36-bit word with a single-cycle valid pulse. It sits between the correlator datapath and the SOPC top.

## Interface
Parameters:
- `CORR_W`, 32: signed correlation sample width.
- `LAG_W`, 12: signed lag width per pair. Fixed: 3*LAG_W = 36.
- `MAX_LAG`, 64: lag range is -MAX_LAG..+MAX_LAG, giving N = 2*MAX_LAG+1 samples per pair. Elaboration error if MAX_LAG >= 2^(LAG_W-1).

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high reset.
- `corr_in`  in  CORR_W  signed correlation value.
- `corr_pair`  in  2  pair index of `corr_in`, 0..2.
- `corr_valid`  in  1  sample present.
- `corr_ready`  out  1  block accepts a sample this cycle.
- `lags_out`  out  36  {lag2, lag1, lag0}, each a LAG_W two's-complement value; drives `lagsin`.
- `lags_out_valid`  out  1  one-cycle pulse when `lags_out` updates; drives `lagsinvalid`.
- `frame_err`  out  1  one-cycle pulse when a frame is aborted.

## Operation
- A sample is accepted when `corr_valid && corr_ready`.
- Frame order:
  - Pair 0 samples at idx 0..N-1, then pair 1 at idx 0..N-1, then pair 2 at idx 0..N-1.
  - idx k corresponds to lag k - MAX_LAG.
- Internal counters: `exp_pair` (0..2) and `idx` (0..N-1). Both advance only on accept.
- Arg-max tracking, per pair:
  - idx 0 loads `best_val` and `best_idx`.
  - For later idx, replace only if `corr_in > best_val` (signed compare, strict).
  - Ties keep the earliest index, i.e. the most negative lag.
- Per-pair result: lag = best_idx - MAX_LAG, sign-extended or truncated to LAG_W. It is stored in the pair's result register when that pair's last sample is accepted.
- FSM states:
  - SCAN: `corr_ready` = 1.
    - On accept with pair 2, idx N-1: go to EMIT.
    - On accept with `corr_pair != exp_pair`: drop the sample, pulse `frame_err`, clear `exp_pair` and `idx` to 0, stay in SCAN.
  - EMIT: `corr_ready` = 0. Load `lags_out` with {r2, r1, r0}, pulse `lags_out_valid`, return to SCAN with `exp_pair` = 0 and `idx` = 0.
- `lags_out` holds its value between emissions. It is never modified on error.
- Reset mid-frame: partial results are discarded and no emission occurs.

## Timing
- Reset values: `lags_out` = 0, `lags_out_valid` = 0, `frame_err` = 0, `corr_ready` = 0 while `reset` is high, FSM = SCAN, counters = 0.
- `corr_ready` is 1 in the first cycle after `reset` deasserts.
- Latency: `lags_out_valid` is high exactly one cycle after the accept of the final pair-2 sample. `lags_out` is valid in that same cycle.
- `corr_ready` is low only during the EMIT cycle.
- Throughput: one sample per cycle; minimum frame period is 3N+1 cycles.
- `frame_err` is high in the cycle after the offending accept.
- `corr_valid` gaps of any length are allowed. No state changes without an accept.

## Structure
- Package `tdoa_pkg`:
  - `LAG_W`, `NUM_PAIRS` = 3, `LAGBUS_W` = 36.
  - `lag_t` typedef.
  - FSM state enum.
  - Function `pack_lags(r0, r1, r2)`.
- Sub-module `argmax_tracker`:
  - Ports: `clk`, `reset`, `start`, `en`, `val`, `idx`.
  - Outputs: `best_idx`, `best_val`.
  - One shared instance, reused per pair. `start` is asserted at idx 0.

## Test plan
- MAX_LAG = 64 (N = 129).
  - Stimulus: one peak per pair: pair 0 at idx 70, pair 1 at idx 64, pair 2 at idx 0; all other values 0.
  - Response: `lags_out` = 36'hFC0000006, `lags_out_valid` high for one cycle, one cycle after the last sample.
- All-zero frame (all ties) -> `lags_out` = 36'hFC0FC0FC0.
- All samples -1000 except -5 at idx 128 in every pair -> `lags_out` = 36'h040040040 (signed compare verified).
- Order violation:
  - Stimulus: during pair 0 at idx 10, send a sample with `corr_pair` = 1.
  - Response: `frame_err` pulse, no valid pulse, `lags_out` unchanged. The next clean frame from the first scenario yields 36'hFC0000006.
- Reset asserted at pair 1, idx 50:
  - Response: all outputs return to their reset values and no valid pulse occurs. The next full frame emits correctly.
- First-scenario frame with `corr_valid` randomly low 50% of cycles:
  - Response: identical `lags_out`.
  - `corr_ready` is low only in the valid-pulse cycle.

Source files
------------

// File: rtl/tdoa_pkg.sv
// Shared types and constants for the TDOA lag producer: lag type, FSM states
// and the helper that packs three per-pair lags onto the 36-bit lag bus.
package tdoa_pkg;

    localparam int LAG_W     = 12;
    localparam int NUM_PAIRS = 3;
    localparam int LAGBUS_W  = 36;

    typedef logic signed [LAG_W-1:0] lag_t;

    typedef enum logic {
        ST_SCAN,
        ST_EMIT
    } state_e;

    function automatic logic [LAGBUS_W-1:0] pack_lags(lag_t r0, lag_t r1, lag_t r2);
        return {r2, r1, r0};
    endfunction

endpackage

// File: rtl/argmax_tracker.sv
// Running signed arg-max over a stream of (val, idx) samples; start restarts
// the search. Outputs already include the sample presented this cycle.
module argmax_tracker
    import tdoa_pkg::*;
#(
    parameter int VAL_W = 32,
    parameter int IDX_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    en,
    input  logic signed [VAL_W-1:0] val,
    input  logic        [IDX_W-1:0] idx,
    output logic        [IDX_W-1:0] best_idx,
    output logic signed [VAL_W-1:0] best_val
);

    logic        [IDX_W-1:0] best_idx_q, best_idx_d;
    logic signed [VAL_W-1:0] best_val_q, best_val_d;
    logic                    take;

    // Strict compare keeps the earliest index on ties.
    assign take = en && (start || (val > best_val_q));

    always_comb begin
        best_idx_d = best_idx_q;
        best_val_d = best_val_q;
        if (take) begin
            best_idx_d = idx;
            best_val_d = val;
        end
    end

    // Forwarded so the last sample of a pair can be folded in on its own accept.
    assign best_idx = best_idx_d;
    assign best_val = best_val_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            best_idx_q <= '0;
            best_val_q <= '0;
        end else begin
            best_idx_q <= best_idx_d;
            best_val_q <= best_val_d;
        end
    end

endmodule

// File: rtl/tdoa_lag_producer.sv
// Tracks the arg-max lag of three microphone pairs over a streamed frame and
// emits the packed lags with a one-cycle valid pulse when the frame completes.
module tdoa_lag_producer
    import tdoa_pkg::*;
#(
    parameter int CORR_W  = 32,
    parameter int LAG_W   = 12,
    parameter int MAX_LAG = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [CORR_W-1:0] corr_in,
    input  logic        [1:0]        corr_pair,
    input  logic                     corr_valid,
    output logic                     corr_ready,
    output logic [LAGBUS_W-1:0]      lags_out,
    output logic                     lags_out_valid,
    output logic                     frame_err
);

    localparam int N      = 2 * MAX_LAG + 1;
    localparam int IDX_W  = $clog2(N);
    localparam int DIFF_W = IDX_W + 2;

    if (3 * LAG_W != LAGBUS_W) begin : g_bad_lag_w
        $error("tdoa_lag_producer: 3*LAG_W must equal the lag bus width");
    end
    if (MAX_LAG >= (1 << (LAG_W - 1))) begin : g_bad_max_lag
        $error("tdoa_lag_producer: MAX_LAG does not fit in a signed LAG_W lag");
    end

    state_e               state_q, state_d;
    logic [1:0]           pair_q, pair_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [LAGBUS_W-1:0]  lags_q, lags_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 store;

    logic                     accept;
    logic                     in_order;
    logic                     last_idx;
    logic                     trk_en;
    logic [IDX_W-1:0]         trk_best_idx;
    logic signed [CORR_W-1:0] unused_best_val;
    logic signed [DIFF_W-1:0] lag_wide;
    lag_t                     cur_lag;

    assign corr_ready = !reset && (state_q == ST_SCAN);
    assign accept     = corr_valid && corr_ready;
    assign in_order   = (corr_pair == pair_q);
    assign last_idx   = (idx_q == IDX_W'(N - 1));
    assign trk_en     = accept && in_order;

    argmax_tracker #(
        .VAL_W (CORR_W),
        .IDX_W (IDX_W)
    ) u_tracker (
        .clk      (clk),
        .reset    (reset),
        .start    (idx_q == '0),
        .en       (trk_en),
        .val      (corr_in),
        .idx      (idx_q),
        .best_idx (trk_best_idx),
        .best_val (unused_best_val)
    );

    assign lag_wide = $signed({2'b00, trk_best_idx}) - $signed(DIFF_W'(MAX_LAG));
    assign cur_lag  = lag_t'(lag_wide);

    // Pair 2's lag goes straight onto the bus, so only pairs 0 and 1 are read back.
    for (genvar gi = 0; gi < NUM_PAIRS; gi++) begin : g_res
        lag_t res_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                res_q <= '0;
            end else if (store && (pair_q == 2'(gi))) begin
                res_q <= cur_lag;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pair_d  = pair_q;
        idx_d   = idx_q;
        lags_d  = lags_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        store   = 1'b0;
        case (state_q)
            ST_SCAN: begin
                if (accept) begin
                    if (!in_order) begin
                        err_d  = 1'b1;
                        pair_d = '0;
                        idx_d  = '0;
                    end else if (last_idx) begin
                        store = 1'b1;
                        idx_d = '0;
                        if (pair_q == 2'd2) begin
                            state_d = ST_EMIT;
                            pair_d  = '0;
                            lags_d  = pack_lags(g_res[0].res_q, g_res[1].res_q, cur_lag);
                            valid_d = 1'b1;
                        end else begin
                            pair_d = pair_q + 2'd1;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_EMIT: begin
                state_d = ST_SCAN;
            end
            default: begin
                state_d = ST_SCAN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_SCAN;
            pair_q  <= '0;
            idx_q   <= '0;
            lags_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pair_q  <= pair_d;
            idx_q   <= idx_d;
            lags_q  <= lags_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign lags_out       = lags_q;
    assign lags_out_valid = valid_q;
    assign frame_err      = err_q;

endmodule

// File: tb/tb_tdoa_lag_producer.sv
// Scoreboard bench for tdoa_lag_producer: directed frames push their expected
// lag word; a monitor checks every cycle's outputs against the expectations.
module tb_tdoa_lag_producer;

    localparam int N = 129;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [31:0] corr_in = '0;
    logic [1:0]         corr_pair = '0;
    logic               corr_valid = 1'b0;
    logic               corr_ready;
    logic [35:0]        lags_out;
    logic               lags_out_valid;
    logic               frame_err;

    logic [35:0] exp_q[$];
    logic [35:0] held_exp = '0;
    logic        is_last_drv = 1'b0;
    logic        bad_drv = 1'b0;
    logic        last_acc_flag = 1'b0;
    logic        err_flag = 1'b0;
    int          errors = 0;
    int          checks = 0;

    tdoa_lag_producer #(
        .CORR_W  (32),
        .LAG_W   (12),
        .MAX_LAG (64)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .corr_in        (corr_in),
        .corr_pair      (corr_pair),
        .corr_valid     (corr_valid),
        .corr_ready     (corr_ready),
        .lags_out       (lags_out),
        .lags_out_valid (lags_out_valid),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    // Which accepts were the final sample of a frame, or a deliberate order violation.
    always @(posedge clk) begin
        last_acc_flag <= corr_valid && corr_ready && is_last_drv;
        err_flag      <= corr_valid && corr_ready && bad_drv;
    end

    always @(posedge clk) begin
        #1;
        if (reset) begin
            held_exp = '0;
            checks++;
            if (lags_out !== 36'h0 || lags_out_valid !== 1'b0 || frame_err !== 1'b0 || corr_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: lags_out=%h valid=%b err=%b ready=%b, required 0/0/0/0",
                         lags_out, lags_out_valid, frame_err, corr_ready);
            end
        end else begin
            checks++;
            if (lags_out_valid !== last_acc_flag) begin
                errors++;
                $display("FAIL valid_timing: lags_out_valid=%b, required %b", lags_out_valid, last_acc_flag);
            end
            if (lags_out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL lags_value: lags_out=%h with no emission expected", lags_out);
                end else begin
                    held_exp = exp_q.pop_front();
                    if (lags_out !== held_exp) begin
                        errors++;
                        $display("FAIL lags_value: lags_out=%h, required %h", lags_out, held_exp);
                    end else begin
                        $display("emit lags_out=%h ok", lags_out);
                    end
                end
            end else begin
                checks++;
                if (lags_out !== held_exp) begin
                    errors++;
                    $display("FAIL lags_hold: lags_out=%h, required %h", lags_out, held_exp);
                end
            end
            checks++;
            if (frame_err !== err_flag) begin
                errors++;
                $display("FAIL frame_err: frame_err=%b, required %b", frame_err, err_flag);
            end else if (frame_err === 1'b1) begin
                $display("frame_err pulse ok");
            end
            checks++;
            if (corr_ready !== !last_acc_flag) begin
                errors++;
                $display("FAIL corr_ready: corr_ready=%b, required %b", corr_ready, !last_acc_flag);
            end
        end
    end

    function automatic logic signed [31:0] sample_val(input int scen, input int p, input int k);
        case (scen)
            0: return ((p == 0 && k == 70) || (p == 1 && k == 64) || (p == 2 && k == 0)) ? 32'sd1000 : 32'sd0;
            1: return 32'sd0;
            default: return (k == 128) ? -32'sd5 : -32'sd1000;
        endcase
    endfunction

    function automatic logic [35:0] exp_word(input int scen);
        case (scen)
            0: return 36'hFC0000006;
            1: return 36'hFC0FC0FC0;
            default: return 36'h040040040;
        endcase
    endfunction

    task automatic put(input logic signed [31:0] v, input logic [1:0] p,
                       input logic last, input logic bad, input bit gaps);
        int guard;
        guard = 0;
        @(negedge clk);
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                corr_valid = 1'b0;
                @(negedge clk);
            end
        end
        corr_in     = v;
        corr_pair   = p;
        is_last_drv = last;
        bad_drv     = bad;
        corr_valid  = 1'b1;
        while (corr_ready !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 10) begin
            checks++;
            errors++;
            $display("FAIL ready_wait: corr_ready=%b for 10 cycles, required 1", corr_ready);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        corr_valid  = 1'b0;
        is_last_drv = 1'b0;
        bad_drv     = 1'b0;
    endtask

    task automatic send_frame(input int scen, input bit gaps);
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < N; k++) begin
                if (p == 2 && k == N - 1) exp_q.push_back(exp_word(scen));
                put(sample_val(scen, p, k), 2'(p), (p == 2 && k == N - 1), 1'b0, gaps);
            end
        end
        idle();
        $display("frame scen=%0d gaps=%0d sent", scen, gaps);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;

        send_frame(0, 1'b0);
        send_frame(1, 1'b0);
        send_frame(2, 1'b0);

        // Order violation during pair 0 at idx 10.
        for (int k = 0; k < 10; k++) put(sample_val(2, 0, k), 2'd0, 1'b0, 1'b0, 1'b0);
        put(32'sd7, 2'd1, 1'b0, 1'b1, 1'b0);
        idle();
        repeat (3) @(negedge clk);
        $display("order violation sent");
        send_frame(0, 1'b0);

        // Reset at pair 1, idx 50.
        for (int k = 0; k < N; k++) put(sample_val(2, 0, k), 2'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 50; k++) put(sample_val(2, 1, k), 2'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        corr_valid = 1'b0;
        reset      = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        $display("mid-frame reset applied");
        send_frame(1, 1'b0);

        send_frame(0, 1'b1);

        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_emits: %0d expected emissions never seen, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
